// File: rtl/circuit9_pkg.sv
// Shared types and helpers for the circuit9 receive-side decoder.
// Encoder law: a=1 -> q<=4; q==6 -> q<=0; else q<=q+1.
package circuit9_pkg;

   localparam logic [2:0] Q_LOAD    = 3'd4;
   localparam logic [2:0] Q_WRAP    = 3'd6;
   localparam logic [2:0] Q_ILLEGAL = 3'd7;

   typedef enum logic {HUNT, LOCK} dec_state_e;

   typedef enum logic [1:0] {
      STEP_A0,
      STEP_A1,
      STEP_AMB,
      STEP_ILL
   } step_e;

   function automatic logic [2:0] inc7(input logic [2:0] x);
      return (x == Q_WRAP) ? 3'd0 : x + 3'd1;
   endfunction

endpackage

// File: rtl/circuit9_step_check.sv
// Classifies one observed transition prev_q -> q of the circuit9 counter.
// Purely combinational.
module circuit9_step_check
   import circuit9_pkg::*;
(
   input  logic [2:0] prev_q,
   input  logic [2:0] q,
   output step_e      step
);

   // 3 -> 4 is both a natural increment and a load, so a is unknown
   always_comb begin
      step = STEP_ILL;
      if (q == Q_ILLEGAL || prev_q == Q_ILLEGAL)
         step = STEP_ILL;
      else if (q == Q_LOAD)
         step = (prev_q == Q_LOAD - 3'd1) ? STEP_AMB : STEP_A1;
      else if (q == inc7(prev_q))
         step = STEP_A0;
      else
         step = STEP_ILL;
   end

endmodule

// File: rtl/circuit9_decoder.sv
// Recovers input a from the circuit9 q stream, tracks lock and errors.
// Optional CIRCUIT9_DEC_STATS_EN adds ones_cnt / amb_cnt outputs.
module circuit9_decoder
   import circuit9_pkg::*;
#(
   parameter int ERR_LIMIT = 3,
   parameter int ERR_W     = 8
) (
   input  logic             clk,
   input  logic             areset,
   input  logic [2:0]       q,
   input  logic             q_valid,
   output logic             a_rec,
   output logic             a_vld,
   output logic             a_amb,
   output logic             err,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
`ifdef CIRCUIT9_DEC_STATS_EN
   ,
   output logic [ERR_W-1:0] ones_cnt,
   output logic [ERR_W-1:0] amb_cnt
`endif
);

   localparam int CW = $clog2(ERR_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(ERR_LIMIT);

   dec_state_e    state;
   logic [2:0]    prev_q;
   logic [CW-1:0] consec;
   logic [CW-1:0] consec_nxt;
   step_e         step;
   logic          ill;
   logic          drop;

   circuit9_step_check u_step (
      .prev_q (prev_q),
      .q      (q),
      .step   (step)
   );

   assign ill        = (step == STEP_ILL);
   assign consec_nxt = ill ? consec + CW'(1) : '0;
   assign drop       = ill && (consec_nxt == LIM);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state   <= HUNT;
         prev_q  <= '0;
         consec  <= '0;
         a_rec   <= 1'b0;
         a_vld   <= 1'b0;
         a_amb   <= 1'b0;
         err     <= 1'b0;
         locked  <= 1'b0;
         err_cnt <= '0;
`ifdef CIRCUIT9_DEC_STATS_EN
         ones_cnt <= '0;
         amb_cnt  <= '0;
`endif
      end else begin
         a_rec <= 1'b0;
         a_vld <= 1'b0;
         a_amb <= 1'b0;
         err   <= 1'b0;
         unique case (state)
            HUNT: begin
               // first good sample only seeds prev_q
               if (q_valid && q != Q_ILLEGAL) begin
                  prev_q <= q;
                  state  <= LOCK;
                  locked <= 1'b1;
               end
            end
            LOCK: begin
               if (!q_valid) begin
                  state  <= HUNT;
                  locked <= 1'b0;
                  consec <= '0;
               end else begin
                  a_vld  <= 1'b1;
                  a_rec  <= (step == STEP_A1);
                  a_amb  <= (step == STEP_AMB);
                  err    <= ill;
                  prev_q <= q;
                  consec <= drop ? '0 : consec_nxt;
                  if (ill && err_cnt != '1)
                     err_cnt <= err_cnt + ERR_W'(1);
`ifdef CIRCUIT9_DEC_STATS_EN
                  if (step == STEP_A1 && ones_cnt != '1)
                     ones_cnt <= ones_cnt + ERR_W'(1);
                  if (step == STEP_AMB && amb_cnt != '1)
                     amb_cnt <= amb_cnt + ERR_W'(1);
`endif
                  if (drop) begin
                     state  <= HUNT;
                     locked <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_circuit9_decoder.sv
// Scoreboard bench for circuit9_decoder: driver queues expectations,
// monitor pops one per clock and compares registered outputs.
module tb_circuit9_decoder;

   logic       clk;
   logic       areset;
   logic [2:0] q;
   logic       q_valid;
   logic       a_rec;
   logic       a_vld;
   logic       a_amb;
   logic       err;
   logic       locked;
   logic [7:0] err_cnt;
`ifdef CIRCUIT9_DEC_STATS_EN
   logic [7:0] ones_cnt;
   logic [7:0] amb_cnt;
`endif

   typedef struct {
      logic v;
      logic r;
      logic a;
      logic e;
      logic l;
      int   ec;
      int   ones;
      int   amb;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   idx = 0;
   int   exp_ones = 0;
   int   exp_amb = 0;

   circuit9_decoder dut (
      .clk     (clk),
      .areset  (areset),
      .q       (q),
      .q_valid (q_valid),
      .a_rec   (a_rec),
      .a_vld   (a_vld),
      .a_amb   (a_amb),
      .err     (err),
      .locked  (locked),
      .err_cnt (err_cnt)
`ifdef CIRCUIT9_DEC_STATS_EN
      ,
      .ones_cnt (ones_cnt),
      .amb_cnt  (amb_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s #%0d got=%0d want=%0d", nm, idx, act, want);
      end
   endtask

   // one sample per negedge; expectation is for the following posedge
   task automatic smp(input logic vv, input logic [2:0] qq,
                      input logic ev, input logic er, input logic ea,
                      input logic ee, input logic el, input int ec);
      exp_t x;
      @(negedge clk);
      q_valid = vv;
      q = qq;
      if (ev && er) exp_ones++;
      if (ev && ea) exp_amb++;
      x = '{ev, er, ea, ee, el, ec, exp_ones, exp_amb};
      sb.push_back(x);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a_vld"}, 32'(a_vld), 0);
      chk({tag, "_a_rec"}, 32'(a_rec), 0);
      chk({tag, "_a_amb"}, 32'(a_amb), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_locked"}, 32'(locked), 0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
`ifdef CIRCUIT9_DEC_STATS_EN
      chk({tag, "_ones"}, 32'(ones_cnt), 0);
      chk({tag, "_amb"}, 32'(amb_cnt), 0);
`endif
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         idx++;
         chk("a_vld", 32'(a_vld), 32'(e.v));
         chk("a_rec", 32'(a_rec), 32'(e.r));
         chk("a_amb", 32'(a_amb), 32'(e.a));
         chk("err", 32'(err), 32'(e.e));
         chk("locked", 32'(locked), 32'(e.l));
         chk("err_cnt", 32'(err_cnt), e.ec);
`ifdef CIRCUIT9_DEC_STATS_EN
         chk("ones_cnt", 32'(ones_cnt), e.ones);
         chk("amb_cnt", 32'(amb_cnt), e.amb);
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int ec;
      areset = 1'b1;
      q_valid = 1'b0;
      q = 3'd0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      areset = 1'b0;

      // lock and plain increments
      smp(1, 3'd5, 0, 0, 0, 0, 1, 0);
      smp(1, 3'd6, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd0, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd1, 1, 0, 0, 0, 1, 0);
      // loads, including 4 -> 4
      smp(1, 3'd4, 1, 1, 0, 0, 1, 0);
      smp(1, 3'd4, 1, 1, 0, 0, 1, 0);
      smp(1, 3'd5, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd6, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd0, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd1, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd2, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd3, 1, 0, 0, 0, 1, 0);
      // ambiguous 3 -> 4
      smp(1, 3'd4, 1, 0, 1, 0, 1, 0);
      smp(1, 3'd5, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd6, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd0, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd1, 1, 0, 0, 0, 1, 0);
      smp(1, 3'd2, 1, 0, 0, 0, 1, 0);
      // three illegal in a row drop lock
      smp(1, 3'd0, 1, 0, 0, 1, 1, 1);
      smp(1, 3'd2, 1, 0, 0, 1, 1, 2);
      smp(1, 3'd0, 1, 0, 0, 1, 0, 3);
      smp(1, 3'd1, 0, 0, 0, 0, 1, 3);
      smp(1, 3'd2, 1, 0, 0, 0, 1, 3);
      // legal steps clear the consecutive count
      smp(1, 3'd0, 1, 0, 0, 1, 1, 4);
      smp(1, 3'd1, 1, 0, 0, 0, 1, 4);
      smp(1, 3'd3, 1, 0, 0, 1, 1, 5);
      smp(1, 3'd4, 1, 0, 1, 0, 1, 5);
      smp(1, 3'd0, 1, 0, 0, 1, 1, 6);
      smp(1, 3'd1, 1, 0, 0, 0, 1, 6);
      // q_valid gap
      smp(0, 3'd0, 0, 0, 0, 0, 0, 6);
      smp(1, 3'd5, 0, 0, 0, 0, 1, 6);
      smp(1, 3'd6, 1, 0, 0, 0, 1, 6);
      // q=7 in HUNT and around LOCK
      smp(0, 3'd0, 0, 0, 0, 0, 0, 6);
      smp(1, 3'd7, 0, 0, 0, 0, 0, 6);
      smp(1, 3'd3, 0, 0, 0, 0, 1, 6);
      smp(1, 3'd7, 1, 0, 0, 1, 1, 7);
      smp(1, 3'd0, 1, 0, 0, 1, 1, 8);
      smp(1, 3'd1, 1, 0, 0, 0, 1, 8);
      smp(0, 3'd0, 0, 0, 0, 0, 0, 8);
      // 300 illegal steps saturate err_cnt
      ec = 8;
      for (int i = 0; i < 100; i++) begin
         smp(1, 3'd0, 0, 0, 0, 0, 1, ec);
         ec = (ec < 255) ? ec + 1 : ec;
         smp(1, 3'd2, 1, 0, 0, 1, 1, ec);
         ec = (ec < 255) ? ec + 1 : ec;
         smp(1, 3'd0, 1, 0, 0, 1, 1, ec);
         ec = (ec < 255) ? ec + 1 : ec;
         smp(1, 3'd2, 1, 0, 0, 1, 0, ec);
      end
      smp(1, 3'd0, 0, 0, 0, 0, 1, 255);
      smp(1, 3'd1, 1, 0, 0, 0, 1, 255);
      // async reset mid-stream
      @(negedge clk);
      areset = 1'b1;
      q_valid = 1'b0;
      exp_ones = 0;
      exp_amb = 0;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      areset = 1'b0;
      smp(1, 3'd5, 0, 0, 0, 0, 1, 0);
      smp(1, 3'd4, 1, 1, 0, 0, 1, 0);
      smp(1, 3'd5, 1, 0, 0, 0, 1, 0);
      @(negedge clk);
      q_valid = 1'b0;
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
